// File: rtl/fetch_pkg.sv
// Shared fetch-side constants and the prefetch FSM state type.
package fetch_pkg;

  localparam int          XLEN_I           = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with synchronous flush; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; emptiness alone hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch into a tagged FWFT queue with redirect flush.
// Optional PF_STATS_EN adds stat_flush_cnt counting discarded instructions.
module if_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
`ifdef PF_STATS_EN
  ,
  output logic [31:0] stat_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e          state;
  logic [XLEN_I-1:0]     fetch_pc;
  logic [XLEN_I-1:0]     inflight_pc;
  logic                  in_flight;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [2*XLEN_I-1:0]   fifo_dout;
  logic                  req_issue;
  logic                  push;
  logic                  pop;

  // Credit counts the word already in flight so the queue can never overflow.
  assign req_issue = (state != ST_IDLE) && !redirect_valid && !fifo_full &&
                     ((fifo_count + CNT_W'(in_flight)) < CNT_W'(DEPTH));
  assign push      = in_flight && !redirect_valid;
  assign pop       = !fifo_empty && out_ready && !redirect_valid;

  assign imem_req_valid = req_issue;
  assign imem_req_addr  = fetch_pc;
  assign out_valid      = !fifo_empty;
  assign out_pc         = fifo_empty ? '0 : fifo_dout[2*XLEN_I-1:XLEN_I];
  assign out_instr      = fifo_empty ? '0 : fifo_dout[XLEN_I-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      in_flight   <= 1'b0;
    end else begin
      in_flight   <= req_issue;
      inflight_pc <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (req_issue)
        fetch_pc <= fetch_pc + 32'd4;
      case (state)
        ST_IDLE:  state <= ST_RUN;
        ST_RUN:   state <= redirect_valid ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state <= redirect_valid ? ST_FLUSH : ST_RUN;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (2*XLEN_I),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({inflight_pc, imem_rdata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef PF_STATS_EN
  logic [32:0] flush_sum;

  // A redirect discards every queued entry plus the word arriving this cycle.
  assign flush_sum = {1'b0, stat_flush_cnt} + 33'(fifo_count) + 33'(in_flight);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stat_flush_cnt <= '0;
    else if (redirect_valid)
      stat_flush_cnt <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
  end
`endif

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, which sets the number of prefetch queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which sets the fetch address loaded on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port imem_req_valid, output, 1 bit: the instruction-memory read strobe.
REQ-006 The block SHALL have port imem_req_addr, output, 32 bits: the byte address of the fetch, word aligned.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: the instruction word, valid exactly one cycle after its request.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: a taken-branch or jump redirect pulse.
REQ-009 The block SHALL have port redirect_pc, input, 32 bits: the redirect target.
REQ-010 The block SHALL have port out_valid, output, 1 bit: an instruction is available to decode/control.
REQ-011 The block SHALL have port out_instr, output, 32 bits: the instruction at the queue head.
REQ-012 The block SHALL have port out_pc, output, 32 bits: the PC of out_instr.
REQ-013 The block SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.

Function
REQ-014 fetch_pc SHALL start at RESET_PC, advance by 4 on each issued request, and wrap modulo 2^32.
REQ-015 A request SHALL issue (imem_req_valid=1, imem_req_addr=fetch_pc) whenever state=RUN and occupancy + in_flight < DEPTH.
REQ-016 The response SHALL be written into the queue at the end of the cycle after its request, together with the request PC as a tag.
REQ-017 The queue SHALL be first-word-fall-through: out_valid=1 whenever it is non-empty, and out_instr/out_pc SHALL be the head entry.
REQ-018 out_instr and out_pc SHALL be 0 whenever out_valid=0.
REQ-019 The head SHALL pop on out_valid && out_ready; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-020 The credit rule (REQ-015) SHALL guarantee no overflow; a push while full is illegal and SHALL be flagged by a bench assertion.
REQ-021 The FSM SHALL have three states: IDLE, RUN and FLUSH.
  - IDLE is entered on reset and SHALL move to RUN after 1 cycle.
  - In RUN, redirect_valid SHALL move the FSM to FLUSH.
  - FLUSH SHALL last 1 cycle and then return to RUN.
REQ-022 On redirect_valid, in the same cycle:
  - the queue SHALL be emptied;
  - any in-flight response SHALL be marked dead and discarded on arrival;
  - fetch_pc SHALL load {redirect_pc[31:2],2'b00};
  - no request SHALL issue.
REQ-023 redirect_valid SHALL take priority over push and pop in the same cycle; out_valid SHALL be 0 in the cycle after a redirect.
REQ-024 Redirect-to-out_valid latency SHALL be 3 cycles: redirect in cycle R, request in R+1, data in R+2, out_valid in R+3.
REQ-025 A redirect while in FLUSH SHALL restart FLUSH with the new target, and the last target SHALL win.
REQ-026 After reset deassertion, the first request SHALL issue in the second cycle and the first out_valid SHALL follow 2 cycles later.

Reset
REQ-027 reset SHALL asynchronously set the following, independent of clk:
  - state=IDLE;
  - fetch_pc=RESET_PC;
  - occupancy=0, pointers=0, in_flight=0;
  - imem_req_valid=0, imem_req_addr=RESET_PC;
  - out_valid=0, out_instr=0, out_pc=0.
REQ-028 Reset asserted mid-operation SHALL discard every queued and in-flight instruction, and no write SHALL occur on the edge where reset deasserts.

Configuration
REQ-029 When macro PF_STATS_EN is defined, the block SHALL add output stat_flush_cnt (32 bits), which increments by the number of queued entries discarded plus 1 for a dead in-flight word, saturates at 32'hFFFF_FFFF, and resets to 0.
REQ-030 Without PF_STATS_EN, the stat_flush_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 The shared package fetch_pkg SHALL hold XLEN_I=32, NOP_INSTR=32'h0000_0013, the DEFAULT_RESET_PC constant, and the enumerated FSM state typedef.
REQ-032 The queue storage SHALL be the sub-module sync_fifo, parameterised on width (64 bits: {pc,instr}) and DEPTH, with push, pop, flush, full, empty and count.

Verification
REQ-033 Reset scenario: reset pulse, then out_ready=1 and imem returning mem[a>>2] -> out_pc sequence 0,4,8,12 on consecutive cycles from cycle 4, with out_instr matching memory.
REQ-034 Backpressure scenario: out_ready=0 for 10 cycles -> exactly 4 requests issue, occupancy=4, and imem_req_valid=0 until out_ready rises, after which there is no loss or duplication.
REQ-035 Redirect scenario: redirect_pc=32'h40 asserted with 3 entries queued and 1 in flight -> out_valid=0 for cycles R+1..R+2, first out_pc=32'h40 at R+3, and stat_flush_cnt +4 with PF_STATS_EN.
REQ-036 Back-to-back redirect scenario: targets 32'h80 then 32'h103 in consecutive cycles -> first out_pc=32'h100 and nothing from 32'h80 is delivered.
REQ-037 Simultaneous push/pop when full scenario: full queue, out_ready=1 continuously -> one instruction delivered per cycle and occupancy never exceeds DEPTH.
REQ-038 Mid-run reset scenario: reset asserted mid-stream with 2 entries queued -> out_valid falls within the same cycle (asynchronously), and the restart fetches from RESET_PC.
